// File: rtl/ysyx_24120013_pkg.sv
// ysyx_24120013_pkg: shared decode encodings and IDU state type
package ysyx_24120013_pkg;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_ADDI = 2'b01,
    CMD_LUI = 2'b10,
    CMD_EBREAK = 2'b11
  } cmd_t;
  typedef enum logic {
    RUN = 1'b0,
    HALT = 1'b1
  } state_t;
endpackage

// File: rtl/ysyx_24120013_idu_dec.sv
// ysyx_24120013_idu_dec: combinational decode of the ADDI/LUI/EBREAK subset
module ysyx_24120013_idu_dec
  import ysyx_24120013_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [19:0]           imm,
  output logic [ADDR_WIDTH-1:0] des_addr,
  output cmd_t                  command,
  output logic                  is_ebreak,
  output logic                  is_illegal
);
  logic is_addi, is_lui;
  always_comb begin
    is_addi = inst[6:0] == OP_IMM && inst[14:12] == 3'b000;
    is_lui = inst[6:0] == LUI;
    is_ebreak = inst == INST_EBREAK;
    is_illegal = !(is_addi || is_lui || is_ebreak);
    command = is_addi ? CMD_ADDI : is_lui ? CMD_LUI : is_ebreak ? CMD_EBREAK : CMD_NOP;
    rs1_addr = is_addi ? ADDR_WIDTH'(inst[19:15]) : '0;
    des_addr = (is_addi || is_lui) ? ADDR_WIDTH'(inst[11:7]) : '0;
    imm = is_addi ? {{8{inst[31]}}, inst[31:20]} : is_lui ? inst[31:12] : '0;
  end
endmodule

// File: rtl/ysyx_24120013_idu.sv
// ysyx_24120013_idu: handshaked decode stage with bubble-safe output register and halt FSM
module ysyx_24120013_idu
  import ysyx_24120013_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [19:0]           imm,
  output logic [ADDR_WIDTH-1:0] des_addr,
  output logic [1:0]            command,
  output logic                  halt,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] dec_cnt
);
  state_t state;
  cmd_t cmd_q, d_cmd;
  logic pending_stop, accept, d_ebreak, d_illegal;
  logic [ADDR_WIDTH-1:0] d_rs1, d_des;
  logic [19:0] d_imm;
  ysyx_24120013_idu_dec #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
    .inst(inst[31:0]),
    .rs1_addr(d_rs1),
    .imm(d_imm),
    .des_addr(d_des),
    .command(d_cmd),
    .is_ebreak(d_ebreak),
    .is_illegal(d_illegal)
  );
  assign in_ready = !rst && state == RUN && !pending_stop && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign halt = state == HALT;
  assign command = cmd_q;
  // once a stop instruction is taken, nothing else enters; its handshake moves us to HALT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pending_stop <= 1'b0;
      illegal <= 1'b0;
      dec_cnt <= '0;
      out_valid <= 1'b0;
      rs1_addr <= '0;
      imm <= '0;
      des_addr <= '0;
      cmd_q <= CMD_NOP;
    end else begin
      if (out_valid && out_ready) dec_cnt <= dec_cnt + 1'b1;
      if (out_valid && out_ready && pending_stop) state <= HALT;
      if (accept) begin
        out_valid <= 1'b1;
        rs1_addr <= d_rs1;
        imm <= d_imm;
        des_addr <= d_des;
        cmd_q <= d_cmd;
        pending_stop <= d_ebreak || d_illegal;
        illegal <= illegal || d_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        rs1_addr <= '0;
        imm <= '0;
        des_addr <= '0;
        cmd_q <= CMD_NOP;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24120013_idu.sv
// tb_ysyx_24120013_idu: directed scenarios plus randomized stream against a bundle-level model
module tb_ysyx_24120013_idu;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic in_ready, out_valid, halt, illegal;
  logic [4:0] rs1_addr, des_addr;
  logic [19:0] imm;
  logic [1:0] command;
  logic [31:0] dec_cnt;
  logic [32:0] bun;
  int tests = 0, fails = 0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [19:0] imm;
    logic [4:0] des;
    logic [1:0] cmd;
    logic ill;
    logic stop;
  } ref_t;

  // model of what the EXU should see: one slot, a count, and stop/halt flags
  logic m_valid, m_pstop, m_halt, m_ill;
  ref_t m_b;
  logic [31:0] m_cnt;

  ysyx_24120013_idu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .rs1_addr(rs1_addr), .imm(imm),
    .des_addr(des_addr), .command(command), .halt(halt), .illegal(illegal), .dec_cnt(dec_cnt)
  );

  always #5 clk = ~clk;
  assign bun = {out_valid, rs1_addr, imm, des_addr, command};

  function automatic ref_t ref_dec(input logic [31:0] i);
    ref_t r = '0;
    if (i[6:0] == 7'h13 && i[14:12] == 3'd0) begin
      r.rs1 = i[19:15]; r.des = i[11:7]; r.imm = {{8{i[31]}}, i[31:20]}; r.cmd = 2'd1;
    end else if (i[6:0] == 7'h37) begin
      r.des = i[11:7]; r.imm = i[31:12]; r.cmd = 2'd2;
    end else if (i == 32'h00100073) begin
      r.cmd = 2'd3; r.stop = 1'b1;
    end else begin
      r.ill = 1'b1; r.stop = 1'b1;
    end
    return r;
  endfunction

  task automatic drive(input logic iv, input logic orr, input logic [31:0] ins);
    @(negedge clk);
    in_valid = iv; out_ready = orr; inst = ins;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 0; m_pstop = 0; m_halt = 0; m_ill = 0; m_b = '0; m_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    @(negedge clk);
    tests++; if ({bun, halt, illegal, dec_cnt} !== '0) begin fails++; $display("FAIL reset_outputs got %h/%b%b/%h exp all 0", bun, halt, illegal, dec_cnt); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_addi();
    apply_reset();
    drive(1, 1, 32'h00308293);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL addi_in_ready got %b exp 1", in_ready); end
    drive(0, 1, 0);
    tests++; if (bun !== {1'b1, 5'd1, 20'h00003, 5'd5, 2'd1}) begin fails++; $display("FAIL addi_bundle got %h exp %h", bun, {1'b1, 5'd1, 20'h00003, 5'd5, 2'd1}); end
    tests++; if (dec_cnt !== 0) begin fails++; $display("FAIL addi_cnt0 got %0d exp 0", dec_cnt); end
    drive(0, 1, 0);
    tests++; if (dec_cnt !== 1 || bun !== '0) begin fails++; $display("FAIL addi_after got cnt %0d bun %h exp 1 / 0", dec_cnt, bun); end
  endtask

  task automatic test_lui_stall();
    apply_reset();
    drive(1, 0, 32'h123453B7);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 32'h00308293);
      tests++; if (bun !== {1'b1, 5'd0, 20'h12345, 5'd7, 2'd2} || in_ready !== 1'b0 || dec_cnt !== 0) begin
        fails++; $display("FAIL lui_stall%0d got bun %h rdy %b cnt %0d", k, bun, in_ready, dec_cnt);
      end
    end
    drive(0, 1, 0);
    tests++; if (bun !== {1'b1, 5'd0, 20'h12345, 5'd7, 2'd2} || dec_cnt !== 0) begin fails++; $display("FAIL lui_release got bun %h cnt %0d", bun, dec_cnt); end
    drive(0, 1, 0);
    tests++; if (dec_cnt !== 1 || out_valid !== 1'b0) begin fails++; $display("FAIL lui_done got cnt %0d valid %b exp 1/0", dec_cnt, out_valid); end
  endtask

  task automatic test_x0();
    apply_reset();
    drive(1, 1, 32'hFFF00013);
    drive(0, 1, 0);
    tests++; if (bun !== {1'b1, 5'd0, 20'hFFFFF, 5'd0, 2'd1}) begin fails++; $display("FAIL x0_bundle got %h exp %h", bun, {1'b1, 5'd0, 20'hFFFFF, 5'd0, 2'd1}); end
    drive(0, 1, 0);
    tests++; if (bun !== '0) begin fails++; $display("FAIL x0_bubble got %h exp 0", bun); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [32:0] exp [4];
    for (int k = 0; k < 4; k++) begin
      logic [31:0] x;
      x = $urandom;
      ins[k] = {x[31:20], x[19:15], 3'b000, x[11:7], 7'h13};
      exp[k] = {1'b1, x[19:15], {{8{x[31]}}, x[31:20]}, x[11:7], 2'd1};
    end
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, ins[k]);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got %b exp 1", k, in_ready); end
      if (k > 0) begin
        tests++; if (bun !== exp[k-1]) begin fails++; $display("FAIL b2b_bundle%0d got %h exp %h", k - 1, bun, exp[k-1]); end
      end
    end
    drive(0, 1, 0);
    tests++; if (bun !== exp[3]) begin fails++; $display("FAIL b2b_bundle3 got %h exp %h", bun, exp[3]); end
    drive(0, 1, 0);
    tests++; if (dec_cnt !== 4 || out_valid !== 1'b0) begin fails++; $display("FAIL b2b_cnt got %0d valid %b exp 4/0", dec_cnt, out_valid); end
  endtask

  task automatic test_ebreak();
    apply_reset();
    drive(1, 1, 32'h00100073);
    drive(1, 1, 32'h00308293);
    tests++; if (bun !== {1'b1, 30'd0, 2'd3} || in_ready !== 1'b0 || halt !== 1'b0) begin fails++; $display("FAIL ebreak_bundle got bun %h rdy %b halt %b", bun, in_ready, halt); end
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h00308293);
      tests++; if ({halt, illegal, in_ready} !== 3'b100 || bun !== '0 || dec_cnt !== 1) begin
        fails++; $display("FAIL ebreak_halt%0d got h/i/r %b%b%b bun %h cnt %0d exp 100/0/1", k, halt, illegal, in_ready, bun, dec_cnt);
      end
    end
    apply_reset();
    #1;
    tests++; if (halt !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL ebreak_rst got halt %b rdy %b exp 0/1", halt, in_ready); end
  endtask

  task automatic test_illegal();
    apply_reset();
    drive(1, 1, 32'hFFFFFFFF);
    drive(0, 0, 0);
    tests++; if (illegal !== 1'b1 || halt !== 1'b0 || bun !== {1'b1, 32'd0}) begin fails++; $display("FAIL illegal_bundle got ill %b halt %b bun %h", illegal, halt, bun); end
    drive(0, 1, 0);
    drive(1, 1, 32'h00308293);
    tests++; if ({halt, illegal, in_ready, out_valid} !== 4'b1100 || dec_cnt !== 1) begin fails++; $display("FAIL illegal_halt got h/i/r/v %b%b%b%b cnt %0d exp 1100/1", halt, illegal, in_ready, out_valid, dec_cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({bun, halt, illegal, dec_cnt, in_ready} !== '0) begin fails++; $display("FAIL illegal_rst got %h/%b%b/%h/%b exp all 0", bun, halt, illegal, dec_cnt, in_ready); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] x, ins;
      logic iv, orr, exp_rdy, hs, acc;
      ref_t d;
      if (m_halt && $urandom_range(0, 3) == 0) apply_reset();
      x = $urandom;
      case ($urandom_range(0, 19))
        0: ins = 32'h00100073;
        1: ins = $urandom;
        2, 3, 4, 5, 6, 7, 8, 9: ins = {x[31:15], 3'b000, x[11:7], 7'h13};
        default: ins = {x[31:7], 7'h37};
      endcase
      iv = $urandom_range(0, 3) != 0;
      orr = $urandom_range(0, 3) != 0;
      drive(iv, orr, ins);
      exp_rdy = !m_halt && !m_pstop && (!m_valid || orr);
      tests++; if ({in_ready, halt, illegal} !== {exp_rdy, m_halt, m_ill}) begin fails++; $display("FAIL rnd%0d_flags got r/h/i %b%b%b exp %b%b%b", c, in_ready, halt, illegal, exp_rdy, m_halt, m_ill); end
      tests++; if (bun !== {m_valid, m_b.rs1, m_b.imm, m_b.des, m_b.cmd} || dec_cnt !== m_cnt) begin
        fails++; $display("FAIL rnd%0d_bundle got %h cnt %0d exp %h cnt %0d", c, bun, dec_cnt, {m_valid, m_b.rs1, m_b.imm, m_b.des, m_b.cmd}, m_cnt);
      end
      hs = m_valid && orr;
      acc = iv && exp_rdy;
      if (hs) m_cnt++;
      if (hs && m_pstop) m_halt = 1;
      if (acc) begin
        d = ref_dec(ins);
        m_b = d; m_valid = 1; m_pstop = d.stop; m_ill = m_ill | d.ill;
      end else if (orr) begin
        m_b = '0; m_valid = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lui_stall();
    test_x0();
    test_back_to_back();
    test_ebreak();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
